// File: rtl/text_defs_pkg.sv
// ---------------------------------------------------------------------------
// text_defs
//   Shared definitions for the on-screen text write path: default screen
//   geometry, the blank glyph code, the ASCII control characters the cursor
//   logic reacts to, the writer state encoding and the decoded-byte bundle
//   produced by ascii_to_glyph.
// ---------------------------------------------------------------------------
package text_defs;

  // Default character grid geometry
  localparam int COLS_DEF = 16;
  localparam int ROWS_DEF = 4;

  // Glyph code of ASCII space; used for clearing and for backspace erase
  localparam logic [5:0] BLANK_CODE = 6'd0;

  // ASCII characters with special meaning to the cursor logic
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_SP = 8'h20;

  // Writer state encoding
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Classification of one input byte
  typedef struct packed {
    logic       printable;
    logic       is_lf;
    logic       is_cr;
    logic       is_bs;
    logic [5:0] code;
  } glyph_t;

endpackage

// File: rtl/ascii_to_glyph.sv
// ---------------------------------------------------------------------------
// ascii_to_glyph
//   Purely combinational byte classifier. Maps ASCII 0x20..0x5F onto glyph
//   codes 0..63, folds lower case 0x61..0x7A onto the upper-case glyphs and
//   flags the three control characters the cursor logic handles.
//   Ports:
//     in_byte : ASCII byte
//     glyph   : {printable, is_lf, is_cr, is_bs, code[5:0]}
// ---------------------------------------------------------------------------
module ascii_to_glyph
  import text_defs::*;
(
  input  logic [7:0] in_byte,
  output glyph_t     glyph
);

  logic [7:0] shifted;

  // The printable window starts at space, so every glyph code is the byte
  // minus 0x20; lower case needs one further 0x20 to land on upper case.
  always_comb begin
    glyph   = '0;
    shifted = '0;
    if (in_byte >= CHR_SP && in_byte <= 8'h5F) begin
      shifted         = in_byte - CHR_SP;
      glyph.printable = 1'b1;
      glyph.code      = shifted[5:0];
    end else if (in_byte >= 8'h61 && in_byte <= 8'h7A) begin
      shifted         = in_byte - 8'h40;
      glyph.printable = 1'b1;
      glyph.code      = shifted[5:0];
    end
    glyph.is_lf = (in_byte == CHR_LF);
    glyph.is_cr = (in_byte == CHR_CR);
    glyph.is_bs = (in_byte == CHR_BS);
  end

endmodule

// File: rtl/text_buffer_writer.sv
// ---------------------------------------------------------------------------
// text_buffer_writer
//   Write side of the text path. Accepts ASCII bytes over valid/ready,
//   writes glyph codes into the character buffer RAM at the text cursor and
//   owns cursor movement (advance, wrap, newline, carriage return,
//   backspace). After reset and on clear_req it sweeps the whole buffer with
//   blank glyphs, one write per cycle.
//   Ports:
//     clk, rst           : clock, asynchronous active-low reset
//     in_valid, in_data  : ASCII byte stream
//     in_ready           : byte accepted when in_valid && in_ready
//     clear_req          : one-cycle pulse that (re)starts a full clear
//     wr_en/addr/data    : buffer write port (addr = row*COLS + col)
//     cur_col, cur_row   : text cursor
//     busy               : high while clearing
// ---------------------------------------------------------------------------
module text_buffer_writer #(
  parameter int         COLS       = text_defs::COLS_DEF,
  parameter int         ROWS       = text_defs::ROWS_DEF,
  parameter int         ADDR_W     = $clog2(COLS*ROWS),
  parameter logic [5:0] BLANK_CODE = text_defs::BLANK_CODE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  input  logic                    clear_req,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [5:0]              wr_data,
  output logic [$clog2(COLS)-1:0] cur_col,
  output logic [$clog2(ROWS)-1:0] cur_row,
  output logic                    busy
);

  import text_defs::*;

  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  localparam logic [COL_W-1:0]  COL_MAX   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  glyph_t            glyph;

  logic [COL_W-1:0]  adv_col;
  logic [ROW_W-1:0]  adv_row;
  logic [ROW_W-1:0]  next_row;
  logic [COL_W-1:0]  bs_col;
  logic [ROW_W-1:0]  bs_row;
  logic              at_origin;

  ascii_to_glyph u_decode (
    .in_byte (in_data),
    .glyph   (glyph)
  );

  // Buffer address of a cursor position
  function automatic logic [ADDR_W-1:0] pos_addr(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

  assign busy     = (state == ST_CLEAR);
  assign in_ready = (state == ST_IDLE) && !clear_req;

  // Candidate cursor positions for each kind of byte. Rows wrap back to the
  // top instead of scrolling; backspace at column 0 climbs to the end of the
  // previous row.
  always_comb begin
    next_row  = (cur_row == ROW_MAX) ? '0 : cur_row + 1'b1;
    adv_col   = (cur_col == COL_MAX) ? '0 : cur_col + 1'b1;
    adv_row   = (cur_col == COL_MAX) ? next_row : cur_row;
    at_origin = (cur_col == '0) && (cur_row == '0);
    if (cur_col != '0) begin
      bs_col = cur_col - 1'b1;
      bs_row = cur_row;
    end else begin
      bs_col = COL_MAX;
      bs_row = cur_row - 1'b1;
    end
  end

  // Clear sweep and byte handling. A clear request always wins over a byte
  // in the same cycle (in_ready is already low), and re-requesting during a
  // sweep restarts it from address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      cur_col <= '0;
      cur_row <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clear_req) begin
            clr_cnt <= '0;
            wr_en   <= 1'b0;
          end else begin
            wr_en   <= 1'b1;
            wr_addr <= clr_cnt;
            wr_data <= BLANK_CODE;
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) begin
              state   <= ST_IDLE;
              clr_cnt <= '0;
              cur_col <= '0;
              cur_row <= '0;
            end
          end
        end

        ST_IDLE: begin
          wr_en <= 1'b0;
          if (clear_req) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end else if (in_valid) begin
            if (glyph.printable) begin
              wr_en   <= 1'b1;
              wr_addr <= pos_addr(cur_row, cur_col);
              wr_data <= glyph.code;
              cur_col <= adv_col;
              cur_row <= adv_row;
            end else if (glyph.is_lf) begin
              cur_col <= '0;
              cur_row <= next_row;
            end else if (glyph.is_cr) begin
              cur_col <= '0;
            end else if (glyph.is_bs && !at_origin) begin
              wr_en   <= 1'b1;
              wr_addr <= pos_addr(bs_row, bs_col);
              wr_data <= BLANK_CODE;
              cur_col <= bs_col;
              cur_row <= bs_row;
            end
          end
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// ---------------------------------------------------------------------------
// tb_text_buffer_writer
//   Self-checking bench for text_buffer_writer (COLS=16, ROWS=4). Expected
//   buffer writes are queued as stimulus is driven and compared by a monitor
//   as the DUT issues them; cursor and handshake checks are inline in each
//   scenario task.
// ---------------------------------------------------------------------------
module tb_text_buffer_writer;

  typedef struct packed {
    logic [5:0] addr;
    logic [5:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clear_req;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [5:0] wr_data;
  logic [3:0] cur_col;
  logic [1:0] cur_row;
  logic       busy;

  int   n_compared;
  int   n_mismatched;
  exp_t sb[$];
  exp_t e;

  text_buffer_writer #(.COLS(16), .ROWS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cur_col   (cur_col),
    .cur_row   (cur_row),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: every write must match the head of the queue, and
  // no byte may be offered as accepted while clearing.
  always @(negedge clk) begin
    if (rst === 1'b1 && wr_en === 1'b1) begin
      n_compared++;
      if (sb.size() == 0) begin
        n_mismatched++;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%0h, expected no write", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          n_mismatched++;
          $display("[TB] FAIL write: got addr=%0d data=%0h, expected addr=%0d data=%0h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
    if (rst === 1'b1 && busy === 1'b1) begin
      n_compared++;
      if (in_ready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL ready_while_busy: got in_ready=%b, expected 0", in_ready);
      end
    end
  end

  task automatic push_write(input int addr, input int data);
    exp_t x;
    x.addr = 6'(addr);
    x.data = 6'(data);
    sb.push_back(x);
  endtask

  task automatic push_clear();
    for (int i = 0; i < 64; i++) push_write(i, 0);
  endtask

  // Wait (bounded) until every queued write has been seen
  task automatic wait_drain(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk); #2;
      if (sb.size() == 0) break;
    end
    n_compared++;
    if (sb.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s_drain: got %0d writes outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  // Offer one byte and hold it until accepted (bounded)
  task automatic send_byte(input logic [7:0] b);
    int k;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = b;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
    end
    if (k == 200) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL accept_timeout: got no in_ready for byte %0h, expected accept", b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string name, input int row, input int col);
    n_compared++;
    if (cur_row !== 2'(row) || cur_col !== 4'(col)) begin
      n_mismatched++;
      $display("[TB] FAIL %s_cursor: got (%0d,%0d), expected (%0d,%0d)", name, cur_row, cur_col, row, col);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1;
    n_compared++;
    if (wr_en !== 1'b0 || wr_addr !== 6'd0 || wr_data !== 6'd0 || busy !== 1'b1 || in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got wr_en=%b addr=%0d data=%0h busy=%b ready=%b, expected 0 0 0 1 0",
               wr_en, wr_addr, wr_data, busy, in_ready);
    end
    check_cursor("reset", 0, 0);
    push_clear();
    rst = 1'b1;
    wait_drain("reset_clear");
    n_compared++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL after_clear: got busy=%b ready=%b, expected busy=0 ready=1", busy, in_ready);
    end
    check_cursor("after_clear", 0, 0);
  endtask

  task automatic test_single_char();
    push_write(0, 8'h21);
    send_byte(8'h41);
    check_cursor("single_a", 0, 1);
    wait_drain("single_a");
  endtask

  task automatic test_back_to_back();
    logic [7:0] ch;
    send_byte(8'h0D);
    check_cursor("cr", 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) begin
      if (i < 10)       ch = 8'h30 + 8'(i);
      else if (i < 16)  ch = 8'h41 + 8'(i - 10);
      else              ch = 8'h78;
      push_write(i, (i == 16) ? 8'h38 : (ch - 8'h20));
      in_valid = 1'b1;
      in_data  = ch;
      @(negedge clk);
      n_compared++;
      if (in_ready !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_ready: got in_ready=%b at byte %0d, expected 1", in_ready, i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_cursor("b2b", 1, 1);
    wait_drain("b2b");
  endtask

  task automatic test_wrap();
    send_byte(8'h0A);
    send_byte(8'h0A);
    check_cursor("lf_to_row3", 3, 0);
    for (int i = 0; i < 15; i++) begin
      push_write(48 + i, 8'h21);
      send_byte(8'h41);
    end
    check_cursor("row3_col15", 3, 15);
    push_write(63, 8'h3A);
    send_byte(8'h5A);
    check_cursor("wrap", 0, 0);
    wait_drain("wrap");
  endtask

  task automatic test_newline_other();
    for (int i = 0; i < 3; i++) send_byte(8'h0A);
    for (int i = 0; i < 5; i++) begin
      push_write(48 + i, 8'h0E);
      send_byte(8'h2E);
    end
    check_cursor("row3_col5", 3, 5);
    send_byte(8'h0A);
    check_cursor("lf_wrap", 0, 0);
    send_byte(8'h7F);
    check_cursor("del_ignored", 0, 0);
    send_byte(8'h60);
    send_byte(8'hFF);
    check_cursor("other_ignored", 0, 0);
    repeat (3) @(negedge clk);
    wait_drain("newline");
  endtask

  task automatic test_backspace();
    send_byte(8'h0A);
    check_cursor("lf_row1", 1, 0);
    push_write(15, 0);
    send_byte(8'h08);
    check_cursor("bs_col0", 0, 15);
    send_byte(8'h0D);
    send_byte(8'h08);
    check_cursor("bs_origin", 0, 0);
    push_write(0, 8'h21);
    send_byte(8'h61);
    push_write(0, 0);
    send_byte(8'h08);
    check_cursor("bs_mid", 0, 0);
    repeat (3) @(negedge clk);
    wait_drain("backspace");
  endtask

  task automatic test_clear_collision();
    int k;
    @(posedge clk); #1;
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h42;
    push_clear();
    push_write(0, 8'h22);
    @(negedge clk);
    n_compared++;
    if (in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL collision_ready: got in_ready=%b, expected 0", in_ready);
    end
    @(posedge clk); #1;
    clear_req = 1'b0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
    end
    if (k == 200) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL collision_accept: got no in_ready, expected accept after clear");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_cursor("collision", 0, 1);
    wait_drain("collision");
  endtask

  task automatic test_clear_restart();
    @(posedge clk); #1;
    clear_req = 1'b1;
    for (int i = 0; i <= 20; i++) push_write(i, 0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_drain("restart_first");
    clear_req = 1'b1;
    push_clear();
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_drain("restart_full");
    repeat (4) @(negedge clk);
    n_compared++;
    if (busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL restart_busy: got busy=%b, expected 0", busy);
    end
    check_cursor("restart", 0, 0);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    clear_req = 1'b1;
    for (int i = 0; i < 10; i++) push_write(i, 0);
    @(posedge clk); #1;
    clear_req = 1'b0;
    wait_drain("mid_partial");
    rst = 1'b0;
    #1;
    sb.delete();
    n_compared++;
    if (wr_en !== 1'b0 || wr_addr !== 6'd0 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL mid_reset: got wr_en=%b addr=%0d busy=%b, expected 0 0 1", wr_en, wr_addr, busy);
    end
    @(posedge clk); #1;
    push_clear();
    rst = 1'b1;
    wait_drain("mid_reclear");
    check_cursor("mid_reclear", 0, 0);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    clear_req = 1'b0;
    test_reset();
    test_single_char();
    test_back_to_back();
    test_wrap();
    test_newline_other();
    test_backspace();
    test_clear_collision();
    test_clear_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
